// File: rtl/pc_seg7_scan_pkg.sv
// Shared constants for the 7-segment display blocks: digit count,
// segment bit positions and the hex glyph table (active-high, {g,f,e,d,c,b,a}).
package pc_seg7_scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Bit position of each segment inside a 7-bit pattern.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs for 0..F, lowercase b and d so they differ from 8 and 0.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/pc_seg7_scan_hex_decode.sv
// Combinational nibble to 7-segment glyph, active-high, shared by display blocks.
module seg7_hex_decode
  import pc_seg7_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Plain table lookup; polarity is left to the caller.
  assign seg_o = HEX_TABLE[nibble_i];

endmodule

// File: rtl/pc_seg7_scan.sv
// Scans a 16-bit value onto a 4-digit multiplexed hex display. The value is
// captured once per frame so a digit never shows half-old, half-new data, and
// the digit-0 decimal point flashes for a while whenever the input changes.
module pc_seg7_scan
  import pc_seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b0,
  parameter int ACT_HOLD       = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W = $clog2(ACT_HOLD + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACT_HOLD);
  localparam logic [1:0]        IDX_LAST = 2'(NUM_DIGITS - 1);

  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [1:0]        idx_q,   idx_d;
  logic [15:0]       snap_q,  snap_d;
  logic [15:0]       prev_q;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic              first_q;
  logic [3:0]        an_q,    an_d;
  logic [6:0]        seg_q,   seg_d;
  logic              dp_q,    dp_d;
  logic              frame_q, frame_d;

  logic        tick;
  logic        load;
  logic        changed;
  logic        blankDigit;
  logic [15:0] dispVal;
  logic [3:0]  nibble;
  logic [3:0]  anOn;
  logic [6:0]  segRaw;
  logic [6:0]  segOn;
  logic        dpOn;

  seg7_hex_decode uDecode (
    .nibble_i (nibble),
    .seg_o    (segRaw)
  );

  // Next-state for prescaler, scan index, snapshot, activity timer and the
  // registered display outputs. Right after reset the snapshot register is
  // still empty, so the glyph comes straight from the value being captured.
  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    load       = first_q | (tick & (idx_q == IDX_LAST));
    snap_d     = load ? value_i : snap_q;
    dispVal    = first_q ? value_i : snap_q;
    changed    = !first_q && (value_i != prev_q);
    hold_d     = hold_q;
    blankDigit = 1'b0;

    if (changed) begin
      hold_d = HOLD_MAX;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    nibble = dispVal[{idx_q, 2'b00} +: 4];

    if (BLANK_LZ) begin
      case (idx_q)
        2'd1:    blankDigit = (dispVal[15:4]  == 12'h000);
        2'd2:    blankDigit = (dispVal[15:8]  == 8'h00);
        2'd3:    blankDigit = (dispVal[15:12] == 4'h0);
        default: blankDigit = 1'b0;
      endcase
    end

    segOn   = blankDigit ? 7'h00 : segRaw;
    anOn    = 4'b0001 << idx_q;
    dpOn    = (idx_q == 2'd0) && (hold_q != '0);
    seg_d   = SEG_ACTIVE_LOW ? ~segOn : segOn;
    an_d    = AN_ACTIVE_LOW  ? ~anOn  : anOn;
    dp_d    = SEG_ACTIVE_LOW ? ~dpOn  : dpOn;
    frame_d = load;
  end

  // State and output registers; reset drops everything back to a blank display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      prev_q  <= 16'h0000;
      hold_q  <= '0;
      first_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      prev_q  <= value_i;
      hold_q  <= hold_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_pc_seg7_scan.sv
// Bench for pc_seg7_scan: two instances (with and without leading-zero
// blanking) driven by directed then random stimulus, compared every cycle
// against a frame-arithmetic model of what the display should show.
module tb_pc_seg7_scan;

  localparam int R     = 4;
  localparam int H     = 8;
  localparam int FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;

  logic [3:0] anA,  anB;
  logic [6:0] segA, segB;
  logic       dpA,  dpB;
  logic       frameA, frameB;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, value seen at each edge, and the
  // edge of the most recent input change.
  int          edgeCount = 0;
  logic [15:0] hist[$];
  int          lastChange = -1;

  always #5 clk = ~clk;

  pc_seg7_scan #(
    .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
    .BLANK_LZ(1'b0), .ACT_HOLD(H)
  ) dutA (
    .clk(clk), .rst(rst), .value_i(value),
    .an_o(anA), .seg_o(segA), .dp_o(dpA), .frame_o(frameA)
  );

  pc_seg7_scan #(
    .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
    .BLANK_LZ(1'b1), .ACT_HOLD(H)
  ) dutB (
    .clk(clk), .rst(rst), .value_i(value),
    .an_o(anB), .seg_o(segB), .dp_o(dpB), .frame_o(frameB)
  );

  // Glyph table written out from the display definition, active-high.
  function automatic logic [6:0] hexPattern(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h edge=%0d t=%0t",
               tag, observed, expected, edgeCount, $time);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model and
  // compare all outputs of both instances just after the edge.
  task automatic applyStimulus(input logic rstIn, input logic [15:0] valIn);
    logic [3:0]  expAn;
    logic [6:0]  expSegA, expSegB;
    logic        expDp, expFrame, act;
    logic [15:0] snap, upper;
    logic [3:0]  nib;
    int          digit, loadEdge;

    rst   = rstIn;
    value = valIn;
    @(posedge clk);

    if (!rstIn) begin
      edgeCount = 0;
      hist.delete();
      lastChange = -1;
      expAn    = 4'hF;
      expSegA  = 7'h7F;
      expSegB  = 7'h7F;
      expDp    = 1'b1;
      expFrame = 1'b0;
    end else begin
      act = (lastChange > 0) && (edgeCount - lastChange < H);
      edgeCount++;
      hist.push_back(valIn);
      if (edgeCount >= 2 && hist[edgeCount-1] != hist[edgeCount-2])
        lastChange = edgeCount;
      digit    = ((edgeCount - 1) / R) % 4;
      loadEdge = ((edgeCount - 1) / FRAME) * FRAME;
      if (loadEdge < 1) loadEdge = 1;
      snap     = hist[loadEdge-1];
      upper    = snap >> (4 * digit);
      nib      = upper[3:0];
      expAn    = ~(4'b0001 << digit);
      expSegA  = ~hexPattern(nib);
      expSegB  = (digit > 0 && upper == 16'h0000) ? 7'h7F : ~hexPattern(nib);
      expDp    = ~((digit == 0) && act);
      expFrame = (edgeCount == 1) || (edgeCount % FRAME == 0);
    end

    #1;
    checkOutput("anA",    {12'h0, anA},    {12'h0, expAn});
    checkOutput("segA",   {9'h0, segA},    {9'h0, expSegA});
    checkOutput("dpA",    {15'h0, dpA},    {15'h0, expDp});
    checkOutput("frameA", {15'h0, frameA}, {15'h0, expFrame});
    checkOutput("anB",    {12'h0, anB},    {12'h0, expAn});
    checkOutput("segB",   {9'h0, segB},    {9'h0, expSegB});
    checkOutput("dpB",    {15'h0, dpB},    {15'h0, expDp});
    checkOutput("frameB", {15'h0, frameB}, {15'h0, expFrame});
  endtask

  initial begin
    logic [15:0] masks [5];
    logic [15:0] cur;
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
    masks[3] = 16'h000F; masks[4] = 16'h0000;

    rst   = 1'b0;
    value = 16'h1234;

    // Reset held with a live input value.
    repeat (3) applyStimulus(1'b0, 16'h1234);

    // First frames after release, then a change while digit 1 is lit.
    repeat (22) applyStimulus(1'b1, 16'h1A8F);
    repeat (40) applyStimulus(1'b1, 16'h0000);

    // Leading-zero blanking patterns.
    repeat (40) applyStimulus(1'b1, 16'h0030);
    repeat (40) applyStimulus(1'b1, 16'h0000);

    // Activity window: single change, then two changes 5 cycles apart.
    repeat (24) applyStimulus(1'b1, 16'h0001);
    repeat (5)  applyStimulus(1'b1, 16'h0003);
    repeat (24) applyStimulus(1'b1, 16'h0004);

    // Reset pulse while digit 2 is being scanned.
    for (int i = 0; i < FRAME && (edgeCount / R) % 4 != 2; i++)
      applyStimulus(1'b1, 16'hBEEF);
    applyStimulus(1'b0, 16'hBEEF);
    repeat (24) applyStimulus(1'b1, 16'hBEEF);

    // Random traffic with many leading zeros and the odd reset.
    cur = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)
        cur = 16'($urandom) & masks[$urandom_range(0, 4)];
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
